// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: byte width, index sizing, serializer state type
// and the highest-kept-byte lookup used to flag the final byte of a beat.
package axis_pkg;

  localparam int BYTE_WIDTH     = 8;
  // Widest keep vector supported (512-bit beats).
  localparam int MAX_KEEP_WIDTH = 64;

  typedef enum logic {
    ST_EMPTY,  // holding register free, accepting a new beat
    ST_SEND    // holding register occupied, emitting bytes
  } ser_state_e;

  // Byte index width; a single-byte beat still needs one bit.
  function automatic int idx_width(input int keep_width);
    return (keep_width > 1) ? $clog2(keep_width) : 1;
  endfunction

  // Index of the highest set bit of keep (0 when keep is zero).
  function automatic int keep_highest_index(input logic [MAX_KEEP_WIDTH-1:0] keep);
    int hi;
    hi = 0;
    for (int k = 0; k < MAX_KEEP_WIDTH; k++) begin
      if (keep[k]) hi = k;
    end
    return hi;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with master/slave views. tkeep is one bit per byte.
interface axis_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int KEEP_WIDTH = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/axis_keep_next_index.sv
// Finds the next kept byte in a keep vector, starting at or after index,
// and reports whether that byte is the highest kept byte of the beat.
module axis_keep_next_index
  import axis_pkg::*;
#(
  parameter int KEEP_WIDTH = 4,
  localparam int IDX_W = idx_width(KEEP_WIDTH)
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  input  logic [IDX_W-1:0]      index,
  input  logic                  inclusive,   // 1: search from index, 0: from index+1
  output logic [IDX_W-1:0]      next_index,
  output logic                  next_valid,
  output logic                  is_last
);

  // Lowest kept position in the search window; descending loop lets the
  // lowest match overwrite the higher ones.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    next_index = '0;
    next_valid = 1'b0;
    for (int k = KEEP_WIDTH - 1; k >= 0; k--) begin
      if (keep[k] && ((k > int'(index)) || (inclusive && (k == int'(index))))) begin
        next_index = IDX_W'(k);
        next_valid = 1'b1;
      end
    end
    is_last = next_valid &&
              (int'(next_index) == keep_highest_index(MAX_KEEP_WIDTH'(keep)));
  end

endmodule

// File: rtl/axis_byte_serializer.sv
// AXI-Stream width downsizer: buffers one input beat and emits its kept
// bytes little-endian, one per clock, on an 8-bit stream. tlast/tuser ride
// on the highest kept byte of the last beat of a frame.
module axis_byte_serializer
  import axis_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 32,
  localparam int KEEP_WIDTH = IN_DATA_WIDTH / BYTE_WIDTH
) (
  input  logic     clk,
  input  logic     reset,     // asynchronous, active low
  axis_if.slave    in_axis,
  axis_if.master   out_axis
);

  localparam int IDX_W = idx_width(KEEP_WIDTH);

  ser_state_e state, state_next;

  // Holding register for one full input beat plus the current byte pointer.
  logic [KEEP_WIDTH-1:0][BYTE_WIDTH-1:0] buf_data;
  logic [KEEP_WIDTH-1:0]                 buf_keep;
  logic                                  buf_last;
  logic                                  buf_user;
  logic [IDX_W-1:0]                      idx;
  logic                                  cur_last;   // idx is the last kept byte

  logic [IDX_W-1:0] first_idx, adv_idx;
  logic             first_valid, first_last;
  logic             adv_valid, adv_last;
  logic             out_fire, in_fire, load, advance;

  // First kept byte of the incoming beat; no match means an all-zero keep.
  axis_keep_next_index #(.KEEP_WIDTH(KEEP_WIDTH)) u_first (
    .keep       (in_axis.tkeep),
    .index      ('0),
    .inclusive  (1'b1),
    .next_index (first_idx),
    .next_valid (first_valid),
    .is_last    (first_last)
  );

  // Next kept byte after the one currently presented.
  axis_keep_next_index #(.KEEP_WIDTH(KEEP_WIDTH)) u_adv (
    .keep       (buf_keep),
    .index      (idx),
    .inclusive  (1'b0),
    .next_index (adv_idx),
    .next_valid (adv_valid),
    .is_last    (adv_last)
  );

  assign out_fire = (state == ST_SEND) && out_axis.tready;
  // Ready when empty, or when the final byte leaves this cycle so the next
  // beat loads without a bubble. Gated by reset so it is low during reset.
  assign in_axis.tready = reset && ((state == ST_EMPTY) || (out_fire && cur_last));
  assign in_fire = in_axis.tvalid && in_axis.tready;
  assign load    = in_fire && first_valid;
  assign advance = out_fire && adv_valid;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of process ordering.
    if (!reset) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Next-state logic: fill on a load, drain after the last kept byte.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (load) state_next = ST_SEND;
      ST_SEND:  if (out_fire && cur_last) state_next = load ? ST_SEND : ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Beat buffer: capture on load, step to the next kept byte on transfer.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the buffer is a handful of flops, not a RAM, so it is reset;
    // that is what makes out_tdata read 0 out of reset.
    if (!reset) begin
      buf_data <= '0;
      buf_keep <= '0;
      buf_last <= 1'b0;
      buf_user <= 1'b0;
      idx      <= '0;
      cur_last <= 1'b0;
    end else if (load) begin
      buf_data <= in_axis.tdata;
      buf_keep <= in_axis.tkeep;
      buf_last <= in_axis.tlast;
      buf_user <= in_axis.tuser;
      idx      <= first_idx;
      cur_last <= first_last;
    end else if (advance) begin
      idx      <= adv_idx;
      cur_last <= adv_last;
    end
  end

  assign out_axis.tvalid = (state == ST_SEND);
  assign out_axis.tdata  = buf_data[idx];
  assign out_axis.tkeep  = 1'b1;
  assign out_axis.tlast  = (state == ST_SEND) && buf_last && cur_last;
  assign out_axis.tuser  = out_axis.tlast && buf_user;

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Directed bench for axis_byte_serializer (32-bit input beats).
module tb_axis_byte_serializer;

  logic clk;
  logic reset;

  axis_if #(.DATA_WIDTH(32), .USER_WIDTH(1)) in_bus ();
  axis_if #(.DATA_WIDTH(8),  .USER_WIDTH(1)) out_bus ();

  axis_byte_serializer #(.IN_DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_axis  (in_bus.slave),
    .out_axis (out_bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         c;
  } xfer_t;

  xfer_t q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_bad = 0;
  int    hs_cyc;

  // Output transfer monitor; cyc numbers the rising edges.
  always @(posedge clk) begin
    if (reset && out_bus.tvalid && out_bus.tready)
      q.push_back('{d: out_bus.tdata, l: out_bus.tlast, u: out_bus.tuser, c: cyc});
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Present a beat at a falling edge, hold it until accepted, and return at
  // the falling edge after the handshake edge (hs_cyc = that edge).
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l, input logic u);
    int n;
    n = 0;
    in_bus.tdata  = d;
    in_bus.tkeep  = k;
    in_bus.tlast  = l;
    in_bus.tuser  = u;
    in_bus.tvalid = 1'b1;
    #1;
    while (!in_bus.tready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", in_bus.tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc - 1;
    in_bus.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare the captured transfers against an expected byte list.
  task automatic check_q(input string tag, input logic [7:0] exp_d[],
                         input int last_at, input logic user_last, input bit contiguous);
    check({tag, "_count"}, q.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q[i].d, exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), q[i].l, (i == last_at));
      check($sformatf("%s_user%0d", tag, i), q[i].u, (i == last_at) ? user_last : 1'b0);
      if (contiguous)
        check($sformatf("%s_cyc%0d", tag, i), q[i].c, hs_cyc + 1 + i);
    end
  endtask

  logic [7:0] seq4[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       pat[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int hs_first;
    int e;
    reset          = 1'b0;
    in_bus.tdata   = '0;
    in_bus.tkeep   = '0;
    in_bus.tlast   = 1'b0;
    in_bus.tuser   = 1'b0;
    in_bus.tvalid  = 1'b0;
    out_bus.tready = 1'b1;

    // Reset state.
    idle(2);
    #1;
    check("rst_in_tready",  in_bus.tready,  1'b0);
    check("rst_out_tvalid", out_bus.tvalid, 1'b0);
    check("rst_out_tdata",  out_bus.tdata,  8'h00);
    check("rst_out_tlast",  out_bus.tlast,  1'b0);
    check("rst_out_tuser",  out_bus.tuser,  1'b0);
    reset = 1'b1;
    idle(1);
    check("post_rst_in_tready", in_bus.tready, 1'b1);

    // Single full beat, cycle by cycle.
    q.delete();
    send_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t1_valid%0d", i),  out_bus.tvalid, 1'b1);
      check($sformatf("t1_data%0d", i),   out_bus.tdata,  seq4[i]);
      check($sformatf("t1_last%0d", i),   out_bus.tlast,  (i == 3));
      check($sformatf("t1_tready%0d", i), in_bus.tready,  (i == 3));
      @(negedge clk);
    end
    #1;
    check("t1_idle_valid", out_bus.tvalid, 1'b0);
    check_q("t1", seq4, 3, 1'b0, 1'b1);

    // Back-to-back beats, second with a single kept byte.
    idle(1);
    q.delete();
    send_beat(32'hDDCCBBAA, 4'hF, 1'b0, 1'b0);
    hs_first = hs_cyc;
    send_beat(32'h00000099, 4'h1, 1'b1, 1'b0);
    hs_cyc = hs_first;
    idle(6);
    check_q("t2", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h99}, 4, 1'b0, 1'b1);

    // Sparse keep with error flag.
    q.delete();
    send_beat(32'h44332211, 4'b1010, 1'b1, 1'b1);
    idle(4);
    check_q("t3", '{8'h22, 8'h44}, 1, 1'b1, 1'b1);

    // Backpressure: bytes hold while stalled.
    q.delete();
    send_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
    e = 0;
    for (int i = 0; i < 6; i++) begin
      out_bus.tready = pat[i];
      #1;
      check($sformatf("t4_hold%0d", i), out_bus.tdata, seq4[e]);
      check($sformatf("t4_last%0d", i), out_bus.tlast, (e == 3));
      @(negedge clk);
      if (pat[i]) e++;
    end
    out_bus.tready = 1'b1;
    idle(2);
    check_q("t4", seq4, 3, 1'b0, 1'b0);

    // Asynchronous reset mid-beat, then a fresh beat from byte 0.
    q.delete();
    send_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_valid",  out_bus.tvalid, 1'b0);
    check("t5_async_tready", in_bus.tready,  1'b0);
    check("t5_async_data",   out_bus.tdata,  8'h00);
    check("t5_pre_rst_xfers", q.size(), 2);
    idle(1);
    reset = 1'b1;
    idle(1);
    #1;
    check("t5_rel_tready", in_bus.tready,  1'b1);
    check("t5_rel_valid",  out_bus.tvalid, 1'b0);
    q.delete();
    send_beat(32'h88776655, 4'hF, 1'b1, 1'b0);
    idle(5);
    check_q("t5", '{8'h55, 8'h66, 8'h77, 8'h88}, 3, 1'b0, 1'b1);

    // All-zero keep beat between two full beats is dropped.
    q.delete();
    send_beat(32'hDDCCBBAA, 4'hF, 1'b0, 1'b0);
    send_beat(32'hEEEEEEEE, 4'h0, 1'b0, 1'b0);
    send_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
    idle(6);
    check_q("t6", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44},
            7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_byte_serializer.md
Name: axis_byte_serializer

Overview:
- Width downsizer for AXI-Stream: accepts beats of IN_DATA_WIDTH bits on a slave AXIS_IF and emits them one byte per beat on an 8-bit master AXIS_IF with TUSER width 1.
- Sits between a user data source and the UDP TX payload path, feeding the payload byte stream of the UDP sender.
- Honours tkeep, tlast and tuser; full throughput (one output byte per clock) when downstream is ready.

Parameters:
- IN_DATA_WIDTH, 32, input tdata width in bits; multiple of 8, range 8..512.
- KEEP_WIDTH, IN_DATA_WIDTH/8, input tkeep width; derived, not overridden.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_tdata  in  IN_DATA_WIDTH  input beat data; byte k = bits [8k+7:8k]. AXIS_IF slave modport.
- in_tkeep  in  KEEP_WIDTH  per-byte valid.
- in_tvalid  in  1  input beat valid.
- in_tready  out  1  input beat accepted when in_tvalid && in_tready.
- in_tlast  in  1  last beat of frame.
- in_tuser  in  1  frame error flag.
- out_tdata  out  8  output byte. AXIS_IF master modport, TDATA_WIDTH 8, TUSER_WIDTH 1.
- out_tvalid  out  1  output byte valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  last byte of frame.
- out_tuser  out  1  error flag, valid with out_tlast.

Behaviour:
- Reset (reset==0, async): holding buffer empty; out_tvalid=0, out_tdata=0, out_tlast=0, out_tuser=0, in_tready=0. After release, in_tready=1 from the first clock edge onward while the buffer is empty.
- Datapath: one holding register for a full input beat (data, keep, last, user) plus a byte index.
- in_tready = buffer empty OR (out_tvalid && out_tready && current byte is last kept byte of buffered beat). Purely combinational from registered state and out_tready. Forced 0 while reset asserted.
- Latency: first byte of an accepted beat is on out_tdata with out_tvalid=1 on the clock edge following the input handshake.
- Byte order: little-endian, byte 0 first. Bytes with tkeep=0 are skipped at no cycle cost; only kept bytes are emitted.
- out_tlast=1 only on the highest-index kept byte of a beat with in_tlast=1. out_tuser = buffered in_tuser on that byte, 0 on all other bytes.
- Beat with tkeep all zero: accepted and dropped, nothing emitted. If it carries tlast, the frame boundary is lost; sources must not send it.
- Output stability: while out_tvalid && !out_tready, out_tdata, out_tlast and out_tuser hold.
- Back-to-back: the last byte of beat N and acceptance of beat N+1 occur in the same cycle; byte 0 of N+1 follows with no bubble.
- IN_DATA_WIDTH==8: behaves as a one-stage register slice with a bubble-free handshake.
- Reset mid-frame: buffered data discarded, outputs return to reset values immediately.

Decomposition:
- Shared package axis_pkg: BYTE_WIDTH=8 and the function keep_highest_index(keep), which returns the index of the highest set bit.
- Sub-module axis_keep_next_index (combinational): takes keep and current index, returns the next set-bit index and an is_last flag.
- The top module holds the buffer registers and handshake logic.

Test Plan:
- Single beat, IN_DATA_WIDTH=32, tdata=32'h44332211, tkeep=4'hF, tlast=1, out_tready=1 -> bytes 11,22,33,44 on four consecutive cycles starting one cycle after the handshake; tlast only on 44; in_tready low for cycles 1-3.
- Two back-to-back beats 32'hDDCCBBAA (tlast=0) then 32'h00000099 with tkeep=4'h1, tlast=1 -> AA,BB,CC,DD,99 in five consecutive cycles; tlast on 99; no bubble.
- Sparse keep, tdata=32'h44332211, tkeep=4'b1010, tlast=1, tuser=1 -> bytes 22,44 on two cycles; 44 has tlast=1 and tuser=1.
- Backpressure: out_tready toggles 1,0,0,1,1,1 during the 4-byte beat -> each byte held stable while stalled; exactly 4 transfers; order preserved.
- Reset asserted (reset=0) asynchronously after the second byte -> out_tvalid=0 without waiting for a clock edge; after release, in_tready=1 and the next beat is emitted from byte 0.
- All-zero keep beat (tkeep=0, tlast=0) between two full beats -> dropped; no output; next beat follows normally.
